// File: rtl/elastic_fifo_pkg.sv
// elastic_fifo_pkg: width helpers and word-lane slicing macro for the elastic FIFO
`define EF_LANE(v, k, w) v[(k)*(w) +: (w)]

package elastic_fifo_pkg;
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/elastic_fifo_mem.sv
// elastic_fifo_mem: unreset register array; ports clk, we/wcnt/waddr/din (PAR_WRITE write lanes), raddr/dout (PAR_READ comb read lanes)
module elastic_fifo_mem
    import elastic_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8,
    parameter int PAR_WRITE = 4,
    parameter int PAR_READ = 2,
    localparam int WCW = cnt_w(PAR_WRITE)
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [WCW-1:0]                 wcnt,
    input  logic [ADDR_WIDTH-1:0]          waddr,
    input  logic [PAR_WRITE*DATA_WIDTH-1:0] din,
    input  logic [ADDR_WIDTH-1:0]          raddr,
    output logic [PAR_READ*DATA_WIDTH-1:0] dout
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk)
        for (int k = 0; k < PAR_WRITE; k++)
            if (we && k < int'(wcnt))
                mem[waddr + ADDR_WIDTH'(k)] <= `EF_LANE(din, k, DATA_WIDTH);

    for (genvar g = 0; g < PAR_READ; g++) begin : g_rd
        assign `EF_LANE(dout, g, DATA_WIDTH) = mem[raddr + ADDR_WIDTH'(g)];
    end
endmodule

// File: rtl/elastic_fifo.sv
// elastic_fifo: variable-width-in/out FIFO; ports clk, rstn, clear, wen/wcnt/din/wack, ren/rcnt/dout/rack, count/space/full/empty, af_thr/ae_thr/almost_full/almost_empty, ovf/udf
module elastic_fifo
    import elastic_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8,
    parameter int PAR_WRITE = 4,
    parameter int PAR_READ = 2,
    localparam int CW = ADDR_WIDTH + 1,
    localparam int WCW = cnt_w(PAR_WRITE),
    localparam int RCW = cnt_w(PAR_READ)
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            clear,
    input  logic                            wen,
    input  logic [WCW-1:0]                  wcnt,
    input  logic [PAR_WRITE*DATA_WIDTH-1:0] din,
    input  logic                            ren,
    input  logic [RCW-1:0]                  rcnt,
    output logic [PAR_READ*DATA_WIDTH-1:0]  dout,
    output logic                            wack,
    output logic                            rack,
    output logic [CW-1:0]                   count,
    output logic [CW-1:0]                   space,
    output logic                            full,
    output logic                            empty,
    input  logic [CW-1:0]                   af_thr,
    input  logic [CW-1:0]                   ae_thr,
    output logic                            almost_full,
    output logic                            almost_empty,
    output logic                            ovf,
    output logic                            udf
);
    localparam int DEPTH = 2**ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] waddr, raddr;
    logic [CW-1:0]         count_next;
    logic                  wreq, rreq;

    assign wreq  = wen && wcnt != '0;
    assign rreq  = ren && rcnt != '0;
    assign space = CW'(DEPTH) - count;
    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;
    assign wack  = !clear && wreq && int'(wcnt) <= PAR_WRITE && CW'(wcnt) <= space;
    assign rack  = !clear && rreq && int'(rcnt) <= PAR_READ && CW'(rcnt) <= count;
    assign count_next = count + (wack ? CW'(wcnt) : '0) - (rack ? CW'(rcnt) : '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn || clear) begin
            waddr        <= '0;
            raddr        <= '0;
            count        <= '0;
            ovf          <= 1'b0;
            udf          <= 1'b0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            if (wack) waddr <= waddr + ADDR_WIDTH'(wcnt);
            if (rack) raddr <= raddr + ADDR_WIDTH'(rcnt);
            count        <= count_next;
            ovf          <= ovf || (wreq && !wack);
            udf          <= udf || (rreq && !rack);
            almost_full  <= count_next >= af_thr;
            almost_empty <= count_next <= ae_thr;
        end
    end

    elastic_fifo_mem #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .PAR_WRITE(PAR_WRITE),
        .PAR_READ(PAR_READ)
    ) u_mem (
        .clk(clk),
        .we(wack),
        .wcnt(wcnt),
        .waddr(waddr),
        .din(din),
        .raddr(raddr),
        .dout(dout)
    );
endmodule

// File: tb/tb_elastic_fifo.sv
// tb_elastic_fifo: directed self-checking bench for elastic_fifo (depth 8, 4-in / 2-out, af 6, ae 1)
module tb_elastic_fifo;
    logic        clk = 1'b0, rstn = 1'b0, clear = 1'b0;
    logic        wen = 1'b0, ren = 1'b0;
    logic [2:0]  wcnt = '0;
    logic [1:0]  rcnt = '0;
    logic [31:0] din = '0;
    logic [15:0] dout;
    logic        wack, rack, full, empty, almost_full, almost_empty, ovf, udf;
    logic [3:0]  count, space;
    logic [3:0]  af_thr = 4'd6, ae_thr = 4'd1;
    int          checks = 0, passed = 0;

    elastic_fifo dut (
        .clk(clk), .rstn(rstn), .clear(clear), .wen(wen), .wcnt(wcnt), .din(din),
        .ren(ren), .rcnt(rcnt), .dout(dout), .wack(wack), .rack(rack),
        .count(count), .space(space), .full(full), .empty(empty),
        .af_thr(af_thr), .ae_thr(ae_thr), .almost_full(almost_full),
        .almost_empty(almost_empty), .ovf(ovf), .udf(udf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input logic w, input int wc, input logic [31:0] d,
                         input logic r, input int rc, input logic c);
        wen = w; wcnt = 3'(wc); din = d; ren = r; rcnt = 2'(rc); clear = c;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        wen = 1'b0; ren = 1'b0; clear = 1'b0; wcnt = '0; rcnt = '0;
    endtask

    initial begin
        #12 rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_space", 32'(space), 8);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_ae", 32'(almost_empty), 1);
        chk("rst_af", 32'(almost_full), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_udf", 32'(udf), 0);

        drive(1, 3, 32'h04030201, 0, 0, 0);
        chk("fill_wack", 32'(wack), 1);
        tick();
        chk("fill_count", 32'(count), 3);
        chk("fill_space", 32'(space), 5);
        chk("fill_dout", 32'(dout), 32'h0201);
        chk("fill_empty", 32'(empty), 0);
        chk("fill_ae", 32'(almost_empty), 0);

        drive(1, 4, 32'h08070605, 0, 0, 0);
        tick();
        chk("f7_count", 32'(count), 7);
        chk("f7_af", 32'(almost_full), 1);
        drive(1, 1, 32'h00000009, 0, 0, 0);
        tick();
        chk("full_count", 32'(count), 8);
        chk("full_full", 32'(full), 1);
        chk("full_af", 32'(almost_full), 1);
        drive(1, 2, 32'h0000EEDD, 0, 0, 0);
        chk("ovf_wack", 32'(wack), 0);
        tick();
        chk("ovf_set", 32'(ovf), 1);
        chk("ovf_count", 32'(count), 8);
        tick();
        chk("ovf_sticky", 32'(ovf), 1);
        chk("ovf_dout", 32'(dout), 32'h0201);

        drive(0, 0, 0, 0, 0, 1);
        tick();
        chk("clr1_ovf", 32'(ovf), 0);
        drive(1, 4, 32'h44332211, 0, 0, 0);
        tick();
        drive(1, 2, 32'h00006655, 0, 0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 1, 2, 0);
            tick();
        end
        chk("pre_wrap_count", 32'(count), 0);
        chk("pre_wrap_ptr", {28'(dut.waddr), 4'(dut.raddr)}, 32'h66);

        drive(1, 0, 32'h12345678, 1, 0, 0);
        chk("zero_wack", 32'(wack), 0);
        chk("zero_rack", 32'(rack), 0);
        tick();
        chk("zero_count", 32'(count), 0);
        chk("zero_ovf", 32'(ovf), 0);
        chk("zero_udf", 32'(udf), 0);

        drive(1, 4, 32'hA3A2A1A0, 0, 0, 0);
        tick();
        chk("wrap_count", 32'(count), 4);
        chk("wrap_dout0", 32'(dout), 32'hA1A0);
        drive(0, 0, 0, 1, 2, 0);
        chk("wrap_rack", 32'(rack), 1);
        tick();
        chk("wrap_dout1", 32'(dout), 32'hA3A2);
        drive(0, 0, 0, 1, 2, 0);
        tick();
        chk("wrap_empty", 32'(empty), 1);
        chk("wrap_ptr", {28'(dut.waddr), 4'(dut.raddr)}, 32'h22);

        drive(1, 4, 32'hB3B2B1B0, 0, 0, 0);
        tick();
        drive(1, 3, 32'h00B6B5B4, 0, 0, 0);
        tick();
        chk("sim_count7", 32'(count), 7);
        drive(1, 2, 32'h0000CCCC, 1, 2, 0);
        chk("sim1_wack", 32'(wack), 0);
        chk("sim1_rack", 32'(rack), 1);
        tick();
        chk("sim1_count", 32'(count), 5);
        chk("sim1_ovf", 32'(ovf), 1);
        chk("sim1_dout", 32'(dout), 32'hB3B2);
        drive(1, 1, 32'h000000B7, 0, 0, 0);
        tick();
        drive(1, 2, 32'h0000C1C0, 1, 2, 0);
        chk("sim2_wack", 32'(wack), 1);
        chk("sim2_rack", 32'(rack), 1);
        tick();
        chk("sim2_count", 32'(count), 6);
        chk("sim2_af", 32'(almost_full), 1);
        chk("sim2_dout", 32'(dout), 32'hB5B4);
        drive(0, 0, 0, 1, 2, 0);
        tick();
        chk("rdwrap_dout", 32'(dout), 32'hB7B6);
        chk("rdwrap_af", 32'(almost_full), 0);
        drive(0, 0, 0, 1, 2, 0);
        tick();
        chk("drain_dout", 32'(dout), 32'hC1C0);
        drive(0, 0, 0, 1, 1, 0);
        tick();
        chk("drain_count", 32'(count), 1);
        chk("drain_lane0", 32'(dout[7:0]), 32'hC1);
        chk("drain_ae", 32'(almost_empty), 1);

        drive(0, 0, 0, 1, 2, 0);
        chk("udf_rack", 32'(rack), 0);
        tick();
        chk("udf_set", 32'(udf), 1);
        chk("udf_count", 32'(count), 1);

        drive(1, 4, 32'hD3D2D1D0, 0, 0, 0);
        tick();
        chk("pre_clr_count", 32'(count), 5);
        chk("pre_clr_af", 32'(almost_full), 0);
        drive(1, 1, 32'h000000EE, 1, 1, 1);
        chk("clr_wack", 32'(wack), 0);
        chk("clr_rack", 32'(rack), 0);
        tick();
        chk("clr_count", 32'(count), 0);
        chk("clr_empty", 32'(empty), 1);
        chk("clr_ovf", 32'(ovf), 0);
        chk("clr_udf", 32'(udf), 0);
        chk("clr_ae", 32'(almost_empty), 1);

        drive(1, 3, 32'h00F2F1F0, 0, 0, 0);
        tick();
        chk("pre_rst_count", 32'(count), 3);
        #2 rstn = 1'b0;
        #1;
        chk("arst_count", 32'(count), 0);
        chk("arst_empty", 32'(empty), 1);
        @(posedge clk);
        #1 rstn = 1'b1;
        chk("arst_hold", 32'(count), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
